// File: rtl/mod15_ctrl_pkg.sv
// Shared encodings and the counter next-value rule for the mod-15 sequencing
// controller, its arbiter and the counter it drives.
package mod15_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'b00,
        CMD_UP    = 2'b01,
        CMD_DOWN  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [3:0] MOD_WRAP = 4'd14;

    // Value the counter takes on the next edge for a given set of controls.
    function automatic logic [3:0] ctr_next(
        input logic [3:0] cur,
        input logic       rst_c,
        input logic       load_c,
        input logic       mode_c,
        input logic [3:0] data_c
    );
        logic [3:0] nxt;
        if (rst_c) begin
            nxt = 4'd0;
        end else if (load_c) begin
            nxt = data_c;
        end else if (cur == MOD_WRAP) begin
            nxt = 4'd0;
        end else if (mode_c) begin
            nxt = cur + 4'd1;
        end else begin
            nxt = cur - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mod15_counter.sv
// Mod-15 up/down counter with synchronous reset and load; wraps 14 -> 0 in
// either direction and has no enable, so holding means reloading its value.
module mod15_counter
    import mod15_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       mode,
    input  logic [3:0] data,
    output logic [3:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'd0;
        end else if (load) begin
            q <= data;
        end else if (q == MOD_WRAP) begin
            q <= 4'd0;
        end else if (mode) begin
            q <= q + 4'd1;
        end else begin
            q <= q - 4'd1;
        end
    end

endmodule

// File: rtl/mod15_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves past the last served
// requester when the controller signals advance.
module mod15_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       last,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    logic ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~last;
        end
    end

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = req[ptr] ? ptr : ~ptr;
    end

endmodule

// File: rtl/mod15_seq_ctrl.sv
// Sequencing controller for an external mod-15 counter: arbitrates two
// requesters, drives the counter and tracks its value in a shadow register.
module mod15_seq_ctrl
    import mod15_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] cmd0,
    input  logic [1:0] cmd1,
    input  logic [3:0] arg0,
    input  logic [3:0] arg1,
    output logic [1:0] ack,
    output logic       busy,
    output logic [3:0] result,
    output logic       ctr_rst,
    output logic       ctr_load,
    output logic       ctr_mode,
    output logic [3:0] ctr_data,
    input  logic [3:0] ctr_q,
    output logic       err,
    output state_t     dbg_state
);

    // Handshake: req[i] is held with cmd/arg stable until ack[i] pulses for
    // one cycle. The ack cycle never grants, so a req still high after it is
    // taken as a fresh request.

    state_t     state;
    cmd_t       cmd_q;
    logic [3:0] arg_q;
    logic [3:0] rem;
    logic [3:0] shadow;
    logic       gnt_q;
    logic       chk_en;

    logic       arb_idx;
    logic       arb_valid;
    logic       grant_ok;
    cmd_t       sel_cmd;
    logic [3:0] sel_arg;

    mod15_rr_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (state == ST_DONE),
        .last      (gnt_q),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign grant_ok  = (state == ST_IDLE) && (ack == 2'b00) && arb_valid;
    assign sel_cmd   = cmd_t'(arb_idx ? cmd1 : cmd0);
    assign sel_arg   = arb_idx ? arg1 : arg0;
    assign dbg_state = state;

    // Default is a reload of the shadow, which holds the enable-less counter.
    always_comb begin
        ctr_rst  = rst;
        ctr_load = 1'b1;
        ctr_mode = 1'b0;
        ctr_data = shadow;
        if (!rst && state == ST_EXEC) begin
            case (cmd_q)
                CMD_LOAD:  ctr_data = arg_q;
                CMD_CLEAR: ctr_rst  = 1'b1;
                default: begin
                    if (rem != 4'd0) begin
                        ctr_load = 1'b0;
                        ctr_mode = (cmd_q == CMD_UP);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cmd_q  <= CMD_LOAD;
            arg_q  <= 4'd0;
            rem    <= 4'd0;
            shadow <= 4'd0;
            gnt_q  <= 1'b0;
            chk_en <= 1'b0;
            ack    <= 2'b00;
            busy   <= 1'b0;
            result <= 4'd0;
            err    <= 1'b0;
        end else begin
            shadow <= ctr_next(shadow, ctr_rst, ctr_load, ctr_mode, ctr_data);
            chk_en <= 1'b1;
            if (chk_en && ctr_q != shadow) begin
                err <= 1'b1;
            end
            ack <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (grant_ok) begin
                        gnt_q <= arb_idx;
                        cmd_q <= sel_cmd;
                        arg_q <= sel_arg;
                        rem   <= sel_arg;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // rem counts steps still to issue; arg 0 leaves after one hold cycle.
                    if (cmd_q == CMD_LOAD || cmd_q == CMD_CLEAR || rem <= 4'd1) begin
                        state <= ST_DONE;
                    end else begin
                        rem <= rem - 4'd1;
                    end
                end
                ST_DONE: begin
                    ack    <= 2'b01 << gnt_q;
                    result <= shadow;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod15_seq_ctrl.sv
// Self-checking bench for mod15_seq_ctrl driving a mod15_counter, with a
// transaction-level model compared every cycle plus directed literal checks.
module tb_mod15_seq_ctrl;
    import mod15_ctrl_pkg::*;

    localparam logic [1:0] C_LOAD  = 2'b00;
    localparam logic [1:0] C_UP    = 2'b01;
    localparam logic [1:0] C_DOWN  = 2'b10;
    localparam logic [1:0] C_CLEAR = 2'b11;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] cmd0 = 2'b00;
    logic [1:0] cmd1 = 2'b00;
    logic [3:0] arg0 = 4'd0;
    logic [3:0] arg1 = 4'd0;
    logic [3:0] inj_mask = 4'd0;
    logic [1:0] ack;
    logic       busy;
    logic [3:0] result;
    logic       ctr_rst;
    logic       ctr_load;
    logic       ctr_mode;
    logic [3:0] ctr_data;
    logic [3:0] q_raw;
    logic [3:0] ctr_q;
    logic       err;
    state_t     dbg_state;

    always #5 clk = ~clk;

    assign ctr_q = q_raw ^ inj_mask;

    mod15_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .cmd0      (cmd0),
        .cmd1      (cmd1),
        .arg0      (arg0),
        .arg1      (arg1),
        .ack       (ack),
        .busy      (busy),
        .result    (result),
        .ctr_rst   (ctr_rst),
        .ctr_load  (ctr_load),
        .ctr_mode  (ctr_mode),
        .ctr_data  (ctr_data),
        .ctr_q     (ctr_q),
        .err       (err),
        .dbg_state (dbg_state)
    );

    mod15_counter u_ctr (
        .clk  (clk),
        .rst  (ctr_rst),
        .load (ctr_load),
        .mode (ctr_mode),
        .data (ctr_data),
        .q    (q_raw)
    );

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, e);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per command: d = 1 for LOAD/CLEAR/arg 0, else arg. Granted at edge g,
    // busy after edges g..g+d, ack after edge g+d+1, next grant from g+d+3.
    int         m_free     = 0;
    int         m_ack_edge = -1;
    int         m_ack_idx  = 0;
    int         m_busy_lo  = 1;
    int         m_busy_hi  = 0;
    logic       m_ptr      = 1'b0;
    logic       m_err      = 1'b0;
    logic       m_armed    = 1'b0;
    logic       started    = 1'b0;
    logic [3:0] m_val      = 4'd0;
    logic [3:0] exp_q[$];

    always @(posedge clk) begin : model
        int idx;
        int d;
        int v;
        logic [1:0] c;
        logic [3:0] a;
        e = e + 1;
        if (rst) begin
            m_free     = e + 1;
            m_ack_edge = -1;
            m_busy_lo  = 1;
            m_busy_hi  = 0;
            m_ptr      = 1'b0;
            m_err      = 1'b0;
            m_armed    = 1'b0;
            m_val      = 4'd0;
            started    = 1'b1;
            exp_q.delete();
        end else begin
            if (m_armed && inj_mask != 4'd0) m_err = 1'b1;
            m_armed = 1'b1;
            if (e >= m_free && req != 2'b00) begin
                idx = (req == 2'b11) ? int'(m_ptr) : (req[1] ? 1 : 0);
                c   = (idx == 1) ? cmd1 : cmd0;
                a   = (idx == 1) ? arg1 : arg0;
                v   = int'(m_val);
                d   = 1;
                case (c)
                    C_LOAD:  v = int'(a);
                    C_CLEAR: v = 0;
                    default: begin
                        d = (a == 4'd0) ? 1 : int'(a);
                        for (int i = 0; i < int'(a); i++) begin
                            if (v == 14)        v = 0;
                            else if (c == C_UP) v = (v + 1) % 16;
                            else                v = (v + 15) % 16;
                        end
                    end
                endcase
                m_val      = v[3:0];
                exp_q.push_back(v[3:0]);
                m_ack_idx  = idx;
                m_ack_edge = e + d + 1;
                m_busy_lo  = e;
                m_busy_hi  = e + d;
                m_free     = e + d + 3;
                m_ptr      = (idx == 0);
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin : compare
        logic [1:0] ea;
        logic       eb;
        if (started) begin
            ea = (e == m_ack_edge) ? ((m_ack_idx == 1) ? 2'b10 : 2'b01) : 2'b00;
            eb = (e >= m_busy_lo) && (e <= m_busy_hi);
            check("ack", ack, ea);
            check("busy", busy, eb);
            check("err", err, m_err);
            if (ea != 2'b00) begin
                check("exp_q_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("result", result, exp_q.pop_front());
            end
            if (!eb) begin
                check("ctr_q_idle", q_raw, m_val);
                check("ctr_load_idle", ctr_load, 1);
                check("ctr_data_idle", ctr_data, m_val);
                check("ctr_rst_idle", ctr_rst, rst);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Latency counts edges from the grant edge to the edge that closes the ack cycle.
    task automatic do_cmd(input int idx, input logic [1:0] c, input logic [3:0] a,
                          input logic [3:0] exp_res, input int exp_lat);
        int k;
        logic seen;
        tick();
        if (idx == 0) begin
            cmd0 = c;
            arg0 = a;
        end else begin
            cmd1 = c;
            arg1 = a;
        end
        req[idx] = 1'b1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            tick();
            k++;
            seen = ack[idx];
        end
        req[idx] = 1'b0;
        check("ack_seen", seen, 1);
        if (seen) begin
            check("latency", k, exp_lat);
            check("result_lit", result, exp_res);
        end
        tick();
    endtask

    // ---------------- stimulus ----------------
    logic [1:0] rr_gnt[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [3:0] rr_res[4] = '{4'd3, 4'd5, 4'd3, 4'd5};

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_ctr_rst", ctr_rst, 1);
        check("rst_result", result, 0);
        rst = 1'b0;
        repeat (20) tick();
        check("idle_q", q_raw, 0);
        check("idle_load", ctr_load, 1);
        check("idle_err", err, 0);

        do_cmd(0, C_LOAD, 4'd9, 4'd9, 3);
        do_cmd(0, C_UP,   4'd7, 4'd1, 9);
        do_cmd(0, C_LOAD, 4'd2, 4'd2, 3);
        do_cmd(0, C_DOWN, 4'd4, 4'd14, 6);
        do_cmd(0, C_DOWN, 4'd1, 4'd0, 3);
        do_cmd(0, C_LOAD, 4'd15, 4'd15, 3);
        do_cmd(0, C_UP,   4'd1, 4'd0, 3);
        do_cmd(0, C_DOWN, 4'd1, 4'd15, 3);
        do_cmd(0, C_UP,   4'd0, 4'd15, 3);
        do_cmd(0, C_CLEAR, 4'd6, 4'd0, 3);
        do_cmd(1, C_LOAD, 4'd7, 4'd7, 3);

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        cmd0 = C_LOAD;
        arg0 = 4'd3;
        cmd1 = C_LOAD;
        arg1 = 4'd5;
        req  = 2'b11;
        for (int n = 0; n < 4; n++) begin
            int k;
            k = 0;
            while (ack == 2'b00 && k < 40) begin
                tick();
                k++;
            end
            check("rr_ack_seen", ack != 2'b00, 1);
            check("rr_grant", ack, rr_gnt[n]);
            check("rr_result", result, rr_res[n]);
            if (n == 3) req = 2'b00;
            tick();
        end

        tick();
        cmd0 = C_UP;
        arg0 = 4'd10;
        req  = 2'b01;
        repeat (5) tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        req = 2'b00;
        repeat (2) begin
            tick();
            check("rst_no_ack", ack, 0);
        end
        check("rst_ctr_q", q_raw, 0);
        rst = 1'b0;
        do_cmd(0, C_LOAD, 4'd6, 4'd6, 3);
        do_cmd(0, C_UP,   4'd3, 4'd9, 5);

        tick();
        inj_mask = 4'h4;
        tick();
        inj_mask = 4'h0;
        repeat (3) tick();
        check("err_set", err, 1);
        repeat (10) tick();
        check("err_sticky", err, 1);
        rst = 1'b1;
        tick();
        check("err_clear", err, 0);
        rst = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d checks made", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mod15_seq_ctrl.md
MOD15_SEQ_CTRL -- requirements
Module: mod15_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; requester count is fixed at 2 and counter width at 4.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req  in  2  per-requester request; held high with cmd/arg stable until matching ack.
REQ-005 cmd0, cmd1  in  2 each  command: 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
REQ-006 arg0, arg1  in  4 each  LOAD value, or step count for UP/DOWN; ignored for CLEAR.
REQ-007 ack  out  2  one-cycle completion pulse to the granted requester.
REQ-008 busy  out  1  high in EXEC and DONE.
REQ-009 result  out  4  counter value at completion; valid while any ack bit is high.
REQ-010 ctr_rst, ctr_load, ctr_mode  out  1 each  drive the mod-15 counter's rst, load, mode.
REQ-011 ctr_data  out  4  drives the counter's data input.
REQ-012 ctr_q  in  4  counter's registered output.
REQ-013 err  out  1  sticky shadow/counter mismatch flag.

Function
REQ-014 Counter rule, modelled in a shadow register: rst -> 0; else load -> data; else value 14 -> 0; else mode 1 -> +1, mode 0 -> -1, both mod 16.
REQ-015 ctr_* outputs SHALL be combinational from state and registers, so the shadow and the counter update on the same edge.
REQ-016 FSM states SHALL be IDLE, EXEC, DONE.
REQ-017 IDLE: ctr_load=1, ctr_data=shadow (hold, since the counter has no enable); arbitrate among req; on grant, latch cmd/arg and grant index, go EXEC.
REQ-018 Arbitration SHALL be 2-way round-robin; the pointer moves past the granted requester on leaving DONE; after reset, requester 0 has priority.
REQ-019 EXEC LOAD: ctr_load=1, ctr_data=arg for one cycle, shadow<=arg, go DONE.
REQ-020 EXEC CLEAR: ctr_rst=1 for one cycle, shadow<=0, go DONE.
REQ-021 EXEC UP/DOWN: ctr_load=0, ctr_mode=1/0, one step per cycle; a down-counter of remaining steps runs and DONE is entered after exactly arg steps.
REQ-022 UP/DOWN with arg=0: zero steps, hold as in IDLE for one cycle, go DONE.
REQ-023 Boundaries: UP from 14 -> 0; DOWN from 14 -> 0; DOWN from 0 -> 15; UP from 15 -> 0; LOAD of 15 is accepted.
REQ-024 DONE: hold as in IDLE, pulse ack[grant]=1, result=shadow, go IDLE.
REQ-025 Request-to-ack latency: LOAD/CLEAR 3 cycles from grant edge; UP/DOWN arg+2 cycles (arg>=1).
REQ-026 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-027 A req dropped before ack is a protocol violation; the command in flight still completes.
REQ-028 err SHALL set when ctr_q != shadow in any cycle after the first post-reset edge, and SHALL hold until rst.

Reset
REQ-029 While rst is high: ctr_rst=1, state=IDLE, shadow=0, rr pointer=0, ack=0, busy=0, result=0, err=0.
REQ-030 rst mid-EXEC SHALL abort the command with no ack; the requester must re-request.

Structure
REQ-031 Package mod15_ctrl_pkg SHALL hold the command encoding, the state encoding and the constant MOD_WRAP=14.
REQ-032 Round-robin grant SHALL be sub-module mod15_rr_arb (inputs req[1:0], advance; outputs grant index and valid).
REQ-033 The counter is instantiated beside the controller, not inside it.

Verification
REQ-034 Reset, then idle 20 cycles -> ctr_q stays 0, ctr_load=1, err=0.
REQ-035 req0 LOAD 9, then req0 UP arg=7 -> result 9, then result 1 (9..14 -> 0 -> 1); ack 9 cycles after the UP grant edge.
REQ-036 LOAD 2, DOWN arg=4 -> result 14 (2,1,0,15,14); then DOWN arg=1 -> result 0.
REQ-037 req0 and req1 raised together and held (LOAD 3, LOAD 5) -> grants alternate 0, 1, 0, 1; result 3, 5, 3, 5.
REQ-038 rst asserted in the middle of UP arg=10 -> no ack, ctr_q=0, then the next command runs normally.
REQ-039 Force ctr_q to differ from the shadow for one cycle -> err rises and stays high until rst.
